// File: rtl/bank_arbiter_if.sv
// Requester-side and bank-side signal bundle for bank_arbiter.
// With ARB_STATS_EN defined the bundle also carries the conflict counters and their clear.
interface bank_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int BANK_N  = 4,
  parameter int ROW_W   = 8,
  parameter int COL_W   = 8,
  parameter int DATA_W  = 8,
  parameter int BADDR_W = ROW_W - $clog2(BANK_N)
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_write;
  logic [N_REQ*ROW_W-1:0]    req_row;
  logic [N_REQ*COL_W-1:0]    req_col;
  logic [N_REQ*DATA_W-1:0]   req_wdata;
  logic [N_REQ-1:0]          req_done;
  logic [N_REQ*DATA_W-1:0]   req_rdata;

  logic [BANK_N-1:0]         bank_read_en;
  logic [BANK_N-1:0]         bank_write_en;
  logic [BANK_N*BADDR_W-1:0] bank_addr;
  logic [BANK_N*COL_W-1:0]   bank_col;
  logic [BANK_N*DATA_W-1:0]  bank_wdata;
  logic [BANK_N-1:0]         bank_ack;
  logic [BANK_N-1:0]         bank_busy;
  logic [BANK_N*DATA_W-1:0]  bank_rdata;

`ifdef ARB_STATS_EN
  logic [BANK_N*16-1:0]      stat_conflict;
  logic                      stat_clear;

  modport slave (
    input  req_valid, req_write, req_row, req_col, req_wdata,
    output req_done, req_rdata,
    output bank_read_en, bank_write_en, bank_addr, bank_col, bank_wdata,
    input  bank_ack, bank_busy, bank_rdata,
    output stat_conflict,
    input  stat_clear
  );

  modport master (
    output req_valid, req_write, req_row, req_col, req_wdata,
    input  req_done, req_rdata,
    input  bank_read_en, bank_write_en, bank_addr, bank_col, bank_wdata,
    output bank_ack, bank_busy, bank_rdata,
    input  stat_conflict,
    output stat_clear
  );
`else
  modport slave (
    input  req_valid, req_write, req_row, req_col, req_wdata,
    output req_done, req_rdata,
    output bank_read_en, bank_write_en, bank_addr, bank_col, bank_wdata,
    input  bank_ack, bank_busy, bank_rdata
  );

  modport master (
    output req_valid, req_write, req_row, req_col, req_wdata,
    input  req_done, req_rdata,
    input  bank_read_en, bank_write_en, bank_addr, bank_col, bank_wdata,
    output bank_ack, bank_busy, bank_rdata
  );
`endif
endinterface

// File: rtl/bank_arbiter.sv
// Round-robin sharing of BANK_N row-bank controllers among N_REQ requesters, one FSM per bank.
// Optional ARB_STATS_EN adds saturating per-bank conflict counters.
module bank_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BANK_N  = 4,
  parameter int ROW_W   = 8,
  parameter int COL_W   = 8,
  parameter int DATA_W  = 8,
  parameter int BADDR_W = ROW_W - $clog2(BANK_N)
) (
  input  logic          clock,
  input  logic          reset,
  bank_arbiter_if.slave bus
);
  localparam int LOG_B  = $clog2(BANK_N);
  localparam int BIDX_W = (BANK_N > 1) ? LOG_B : 1;
  localparam int OWN_W  = $clog2(N_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_COMMIT, ST_DONE} state_t;

  state_t             r_state [BANK_N];
  logic [OWN_W-1:0]   r_ptr   [BANK_N];
  logic [OWN_W-1:0]   r_owner [BANK_N];
  logic [BANK_N-1:0]  r_write;
  logic [BADDR_W-1:0] r_addr  [BANK_N];
  logic [COL_W-1:0]   r_col   [BANK_N];
  logic [DATA_W-1:0]  r_wdata [BANK_N];
  logic [DATA_W-1:0]  r_rdata [N_REQ];

  logic [BIDX_W-1:0]  w_req_bank [N_REQ];
  logic [BADDR_W-1:0] w_req_addr [N_REQ];
  logic [N_REQ-1:0]   w_owned;
  logic [N_REQ-1:0]   w_hold;
  logic               w_unused;

  // bank_busy only lengthens ISSUE, which waiting on ack already covers.
  assign w_unused = ^bus.bank_busy;

  always_comb begin
    for (int r = 0; r < N_REQ; r++) begin
      w_req_bank[r] = BIDX_W'(bus.req_row[r*ROW_W +: ROW_W] & ROW_W'(BANK_N - 1));
      w_req_addr[r] = BADDR_W'(bus.req_row[r*ROW_W +: ROW_W] >> LOG_B);
    end
  end

  // A requester stays owned from grant through its DONE cycle, so its
  // still-high req_valid cannot trigger a second grant.
  always_comb begin
    w_owned = '0;
    w_hold  = '0;
    for (int b = 0; b < BANK_N; b++) begin
      if (r_state[b] != ST_IDLE)
        w_owned[r_owner[b]] = 1'b1;
      if (r_state[b] == ST_ISSUE || r_state[b] == ST_COMMIT)
        w_hold[r_owner[b]] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < BANK_N; gi++) begin : g_bank
      logic [N_REQ-1:0] w_cand;
      logic             w_grant_valid;
      logic [OWN_W-1:0] w_grant_idx;
      state_t           w_state_next;

      always_comb begin
        w_cand = '0;
        for (int r = 0; r < N_REQ; r++)
          w_cand[r] = bus.req_valid[r] && (w_req_bank[r] == BIDX_W'(gi)) && !w_owned[r];
      end

      // Scanning from the far end lets the candidate closest to the pointer win last.
      always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
          if (w_cand[OWN_W'(r_ptr[gi] + OWN_W'(k))]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = OWN_W'(r_ptr[gi] + OWN_W'(k));
          end
        end
      end

      always_comb begin
        w_state_next = r_state[gi];
        case (r_state[gi])
          ST_IDLE:   if (w_grant_valid) w_state_next = ST_ISSUE;
          ST_ISSUE:  if (bus.bank_ack[gi]) w_state_next = r_write[gi] ? ST_COMMIT : ST_DONE;
          ST_COMMIT: w_state_next = ST_DONE;
          ST_DONE:   w_state_next = ST_IDLE;
          default:   w_state_next = ST_IDLE;
        endcase
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          r_state[gi] <= ST_IDLE;
          r_ptr[gi]   <= '0;
          r_owner[gi] <= '0;
          r_write[gi] <= 1'b0;
          r_addr[gi]  <= '0;
          r_col[gi]   <= '0;
          r_wdata[gi] <= '0;
        end else begin
          r_state[gi] <= w_state_next;
          if (r_state[gi] == ST_IDLE && w_grant_valid) begin
            r_owner[gi] <= w_grant_idx;
            r_write[gi] <= bus.req_write[w_grant_idx];
            r_addr[gi]  <= w_req_addr[w_grant_idx];
            r_col[gi]   <= bus.req_col[w_grant_idx*COL_W +: COL_W];
            r_wdata[gi] <= bus.req_wdata[w_grant_idx*DATA_W +: DATA_W];
          end
          if (r_state[gi] == ST_DONE)
            r_ptr[gi] <= r_owner[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // Ownership is exclusive, so at most one bank writes a given requester's slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < N_REQ; r++)
        r_rdata[r] <= '0;
    end else begin
      for (int b = 0; b < BANK_N; b++)
        if (r_state[b] == ST_ISSUE && bus.bank_ack[b] && !r_write[b])
          r_rdata[r_owner[b]] <= bus.bank_rdata[b*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bus.req_done      = '0;
    bus.req_rdata     = '0;
    bus.bank_read_en  = '0;
    bus.bank_write_en = '0;
    bus.bank_addr     = '0;
    bus.bank_col      = '0;
    bus.bank_wdata    = '0;
    for (int r = 0; r < N_REQ; r++)
      bus.req_rdata[r*DATA_W +: DATA_W] = r_rdata[r];
    for (int b = 0; b < BANK_N; b++) begin
      if (r_state[b] == ST_DONE)
        bus.req_done[r_owner[b]] = 1'b1;
      bus.bank_read_en[b]                  = (r_state[b] == ST_ISSUE) && !r_write[b];
      bus.bank_write_en[b]                 = (r_state[b] == ST_ISSUE) && r_write[b];
      bus.bank_addr[b*BADDR_W +: BADDR_W]  = r_addr[b];
      bus.bank_col[b*COL_W +: COL_W]       = r_col[b];
      bus.bank_wdata[b*DATA_W +: DATA_W]   = r_wdata[b];
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_stat [BANK_N];

  generate
    for (genvar gi = 0; gi < BANK_N; gi++) begin : g_stat
      logic w_conflict;

      // A valid request for this bank that is not the owner is waiting on it.
      always_comb begin
        w_conflict = 1'b0;
        if (r_state[gi] == ST_IDLE || r_state[gi] == ST_ISSUE)
          for (int r = 0; r < N_REQ; r++)
            if (bus.req_valid[r] && w_req_bank[r] == BIDX_W'(gi) &&
                !(r_state[gi] != ST_IDLE && r_owner[gi] == OWN_W'(r)))
              w_conflict = 1'b1;
      end

      always_ff @(posedge clock) begin
        if (!reset || bus.stat_clear)
          r_stat[gi] <= '0;
        else if (w_conflict && r_stat[gi] != 16'hFFFF)
          r_stat[gi] <= r_stat[gi] + 16'd1;
      end

      assign bus.stat_conflict[gi*16 +: 16] = r_stat[gi];
    end
  endgenerate
`endif

`ifndef SYNTHESIS
  // Requesters must keep req_valid high until their access completes.
  always @(posedge clock) begin
    if (reset)
      for (int r = 0; r < N_REQ; r++)
        assert (!(w_hold[r] && !bus.req_valid[r]));
  end
`endif
endmodule
